// File: rtl/dff_rising_edge_pkg.sv
// Shared constants for the rising-edge flop family.
// Default register width used by the flop and its interface.
package dff_rising_edge_pkg;

  localparam int unsigned DFF_W_DEFAULT = 1;

endpackage

// File: rtl/dff_rising_edge_if.sv
// Data bundle around one flop register: next-state in, state out.
// The master drives d and reads q; the slave is the register itself.
interface dff_rising_edge_if
  import dff_rising_edge_pkg::*;
#(
  parameter int WIDTH = DFF_W_DEFAULT
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (
    output d,
    input  q
  );

  modport slave (
    input  d,
    output q
  );

endinterface

// File: rtl/dff_rising_edge_bit.sv
// One-bit rising-edge flop cell with asynchronous active-low reset.
// Replicated by dff_rising_edge to build registers of any width.
module dff_rising_edge_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_d,
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_q
);

  logic r_q;

  // reset forces the state at once; otherwise capture d on clk rise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_rising_edge.sv
// Parameterised rising-edge D register with async active-low reset.
// Port order (d, clk, rst, q) is kept for positional instances.
module dff_rising_edge
  import dff_rising_edge_pkg::*;
#(
  parameter int              WIDTH       = DFF_W_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] w_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dff_rising_edge_bit #(
      .RESET_VALUE (RESET_VALUE[g])
    ) u_bit (
      .i_d     (d[g]),
      .i_clk   (clk),
      .i_rst_n (rst),
      .o_q     (w_q[g])
    );
  end

  assign q = w_q;

endmodule

// File: tb/tb_dff_rising_edge.sv
// Directed bench for dff_rising_edge: 1-bit, 3-bit with reset value,
// and a 3-bit controller state register built from 1-bit instances.
`timescale 1ns/1ns
module tb_dff_rising_edge;

  logic clk;
  logic rst;
  logic start;
  int   n_chk;
  int   n_err;

  dff_rising_edge_if #(.WIDTH(1)) u_if1 ();
  dff_rising_edge_if #(.WIDTH(3)) u_if3 ();

  dff_rising_edge #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_dut1 (
    .d   (u_if1.d),
    .clk (clk),
    .rst (rst),
    .q   (u_if1.q)
  );

  dff_rising_edge #(
    .WIDTH       (3),
    .RESET_VALUE (3'b101)
  ) u_dut3 (
    .d   (u_if3.d),
    .clk (clk),
    .rst (rst),
    .q   (u_if3.q)
  );

  logic [2:0] sm_d;
  logic       sm_q0;
  logic       sm_q1;
  logic       sm_q2;
  logic [2:0] v;

  assign v = {sm_q2, sm_q1, sm_q0};

  always_comb begin
    sm_d = 3'd0;
    case (v)
      3'd0:    sm_d = start ? 3'd1 : 3'd0;
      3'd1:    sm_d = 3'd2;
      3'd2:    sm_d = 3'd3;
      3'd3:    sm_d = 3'd4;
      3'd4:    sm_d = 3'd5;
      3'd5:    sm_d = 3'd2;
      default: sm_d = 3'd0;
    endcase
  end

  dff_rising_edge u_sm0 (.d(sm_d[0]), .clk(clk), .rst(rst), .q(sm_q0));
  dff_rising_edge u_sm1 (.d(sm_d[1]), .clk(clk), .rst(rst), .q(sm_q1));
  dff_rising_edge u_sm2 (.d(sm_d[2]), .clk(clk), .rst(rst), .q(sm_q2));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic       d1v [4];
  logic [2:0] d3v [4];
  logic [2:0] smv [6];
  logic       p1;
  logic [2:0] p3;

  initial begin
    n_chk = 0;
    n_err = 0;
    d1v = '{1'b1, 1'b0, 1'b1, 1'b0};
    d3v = '{3'b100, 3'b001, 3'b110, 3'b010};
    smv = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd2, 3'd3};
    rst     = 1'b1;
    start   = 1'b0;
    u_if1.d = 1'b0;
    u_if3.d = 3'b000;

    // async reset before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_async_q1", 8'(u_if1.q), 8'd0);
    chk("rst_async_q3", 8'(u_if3.q), 8'b101);

    // reset held over 3 edges while d toggles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      u_if1.d = ~u_if1.d;
      u_if3.d = (i == 1) ? 3'b111 : 3'b010;
      @(posedge clk);
      #1;
      chk("rst_hold_q1", 8'(u_if1.q), 8'd0);
      chk("rst_hold_q3", 8'(u_if3.q), 8'b101);
    end

    // release 2ns before a rise with d=1
    @(posedge clk);
    #8;
    u_if1.d = 1'b1;
    u_if3.d = 3'b011;
    #10 rst = 1'b1;
    #1;
    chk("rel_noncap_q1", 8'(u_if1.q), 8'd0);
    chk("rel_noncap_q3", 8'(u_if3.q), 8'b101);
    @(posedge clk);
    #1;
    chk("rel_cap_q1", 8'(u_if1.q), 8'd1);
    chk("rel_cap_q3", 8'(u_if3.q), 8'b011);

    // follow alternating data, one edge of latency
    p1 = 1'b1;
    p3 = 3'b011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if1.d = d1v[i];
      u_if3.d = d3v[i];
      #1;
      chk("lat_hold_q1", 8'(u_if1.q), 8'(p1));
      chk("lat_hold_q3", 8'(u_if3.q), 8'(p3));
      @(posedge clk);
      #1;
      chk("follow_q1", 8'(u_if1.q), 8'(d1v[i]));
      chk("follow_q3", 8'(u_if3.q), 8'(d3v[i]));
      p1 = d1v[i];
      p3 = d3v[i];
    end

    // mid-cycle pulse on d, spanning the falling edge
    #2;
    u_if1.d = 1'b1;
    u_if3.d = 3'b111;
    #8;
    chk("negedge_q1", 8'(u_if1.q), 8'd0);
    chk("negedge_q3", 8'(u_if3.q), 8'b010);
    #4;
    u_if1.d = 1'b0;
    u_if3.d = 3'b010;
    @(posedge clk);
    #1;
    chk("pulse_q1", 8'(u_if1.q), 8'd0);
    chk("pulse_q3", 8'(u_if3.q), 8'b010);

    // reset mid-operation, 5ns after a rise
    @(negedge clk);
    u_if1.d = 1'b1;
    u_if3.d = 3'b110;
    @(posedge clk);
    #1;
    chk("pre_mid_q1", 8'(u_if1.q), 8'd1);
    chk("pre_mid_q3", 8'(u_if3.q), 8'b110);
    #4 rst = 1'b0;
    #1;
    chk("mid_rst_q1", 8'(u_if1.q), 8'd0);
    chk("mid_rst_q3", 8'(u_if3.q), 8'b101);
    @(posedge clk);
    #1;
    chk("mid_hold_q1", 8'(u_if1.q), 8'd0);
    chk("mid_hold_q3", 8'(u_if3.q), 8'b101);

    // reset asserted on the same timestep as a clk rise
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("recap_q1", 8'(u_if1.q), 8'd1);
    chk("recap_q3", 8'(u_if3.q), 8'b110);
    @(negedge clk);
    #10 rst = 1'b0;
    #1;
    chk("rst_wins_q1", 8'(u_if1.q), 8'd0);
    chk("rst_wins_q3", 8'(u_if3.q), 8'b101);

    // controller state register from three 1-bit flops
    start = 1'b1;
    #1;
    chk("sm_in_rst", 8'(v), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sm_rel", 8'(v), 8'd0);
    #7;
    chk("sm_pre_edge", 8'(v), 8'd0);
    @(posedge clk);
    #1;
    chk("sm_s1", 8'(v), 8'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("sm_seq", 8'(v), 8'(smv[i]));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
